// File: rtl/array_update_scheduler.sv
// array_update_scheduler: two-requester round-robin arbiter feeding a 2-stage single-element array update pipe
// Ports: clk/rst (sync, active-high); hold blocks grants; init_valid/init_data load the whole array;
// req0_*/req1_* valid/ready/index/value update requests; array_out is the registered array (elem 0 at LSBs);
// upd_done/upd_src/upd_err describe the update retired at the last edge.
// Option ARRAY_UPD_SCHED_STATS_EN adds upd_count, a saturating count of in-range retired updates.
module array_update_scheduler #(
  parameter int NUM_ELEMS = 4,
  parameter int ELEM_W    = 33,
  parameter int IDX_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        init_valid,
  input  logic [NUM_ELEMS*ELEM_W-1:0] init_data,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [IDX_W-1:0]            req0_index,
  input  logic [ELEM_W-1:0]           req0_value,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [IDX_W-1:0]            req1_index,
  input  logic [ELEM_W-1:0]           req1_value,
  output logic [NUM_ELEMS*ELEM_W-1:0] array_out,
  output logic                        upd_done,
  output logic                        upd_src,
`ifdef ARRAY_UPD_SCHED_STATS_EN
  output logic [15:0]                 upd_count,
`endif
  output logic                        upd_err
);
  logic [NUM_ELEMS-1:0][ELEM_W-1:0] r_arr;
  logic                             r_rr_last;
  logic                             r_s0_valid;
  logic                             r_s0_src;
  logic [IDX_W-1:0]                 r_s0_idx;
  logic [ELEM_W-1:0]                r_s0_val;
  logic                             r_upd_done;
  logic                             r_upd_src;
  logic                             r_upd_err;
  logic                             w_g0;
  logic                             w_g1;
  logic                             w_in_range;
  // rr_last=1 means requester 1 won last, so requester 0 has priority on a tie
  always_comb begin
    w_g0       = !rst && !hold && req0_valid && (!req1_valid || r_rr_last);
    w_g1       = !rst && !hold && req1_valid && (!req0_valid || !r_rr_last);
    w_in_range = r_s0_idx < IDX_W'(NUM_ELEMS);
  end
  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign array_out  = r_arr;
  assign upd_done   = r_upd_done;
  assign upd_src    = r_upd_src;
  assign upd_err    = r_upd_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arr      <= '0;
      r_rr_last  <= 1'b1;
      r_s0_valid <= 1'b0;
      r_s0_src   <= 1'b0;
      r_s0_idx   <= '0;
      r_s0_val   <= '0;
      r_upd_done <= 1'b0;
      r_upd_src  <= 1'b0;
      r_upd_err  <= 1'b0;
    end else begin
      r_s0_valid <= w_g0 || w_g1;
      if (w_g0 || w_g1) begin
        r_s0_src  <= w_g1;
        r_s0_idx  <= w_g1 ? req1_index : req0_index;
        r_s0_val  <= w_g1 ? req1_value : req0_value;
        r_rr_last <= w_g1;
      end
      r_upd_done <= r_s0_valid;
      r_upd_err  <= r_s0_valid && !w_in_range;
      if (r_s0_valid)
        r_upd_src <= r_s0_src;
      // full-width index match per element; a retiring update overrides init_data for its element
      for (int i = 0; i < NUM_ELEMS; i++)
        r_arr[i] <= (r_s0_valid && r_s0_idx == IDX_W'(i)) ? r_s0_val :
                    init_valid ? init_data[i*ELEM_W +: ELEM_W] : r_arr[i];
    end
  end
`ifdef ARRAY_UPD_SCHED_STATS_EN
  logic [15:0] r_upd_count;
  assign upd_count = r_upd_count;
  always_ff @(posedge clk) begin
    if (rst)
      r_upd_count <= '0;
    else if (r_s0_valid && w_in_range && r_upd_count != 16'hFFFF)
      r_upd_count <= r_upd_count + 16'd1;
  end
`endif
endmodule
